rr_mux_scheduler: RTL

RR_MUX_SCHEDULER -- requirements
Module: rr_mux_scheduler

---
 rtl/rr_mux_pkg.sv | 16 +
 rtl/mux4_sel.sv | 24 ++
 rtl/rr_mux_scheduler.sv | 87 ++++++++
 3 files changed

// File: rtl/rr_mux_pkg.sv
// Shared constants, state encoding and grant encoding for the round-robin mux scheduler.
package rr_mux_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/mux4_sel.sv
// Four-way word selector; purely combinational.
module mux4_sel
  import rr_mux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_REQ-1:0][W-1:0] words,
  output logic [W-1:0]              word
);

  // select one word by index
  always_comb begin
    word = {W{1'b0}};
    case (sel)
      2'd0:    word = words[0];
      2'd1:    word = words[1];
      2'd2:    word = words[2];
      2'd3:    word = words[3];
      default: word = {W{1'b0}};
    endcase
  end

endmodule

// File: rtl/rr_mux_scheduler.sv
// Round-robin scheduler capturing one requester word into a single-entry
// valid/ready output holding register.
module rr_mux_scheduler
  import rr_mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_i,
  input  logic [NUM_REQ-1:0]                 mask_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]     data_i,
  output logic [NUM_REQ-1:0]                 ack_o,
  output logic                               out_valid_o,
  output logic [DATA_W-1:0]                  out_data_o,
  output logic [SEL_W-1:0]                   out_src_o,
  input  logic                               out_ready_i
);

  state_t             state_r, state_nx_s;
  logic [SEL_W-1:0]   last_r, win_s, src_r;
  logic [DATA_W-1:0]  data_r, mux_word_s;
  logic [NUM_REQ-1:0] elig_s;
  logic               xfer_s, capture_s;

  assign elig_s    = req_i & mask_i;
  assign xfer_s    = (state_r == HOLD) && out_ready_i;
  // rst_n gates capture so no acknowledge escapes while reset is held
  assign capture_s = rst_n && ((state_r == IDLE) || xfer_s) && (|elig_s);

  // round-robin search: lowest offset from last wins, offset NUM_REQ is last itself
  always_comb begin
    logic [SEL_W-1:0] cand;
    cand  = {SEL_W{1'b0}};
    win_s = last_r;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand  = last_r + SEL_W'(i);
      win_s = elig_s[cand] ? cand : win_s;
    end
  end

  mux4_sel #(.W(DATA_W)) u_mux (
    .sel   (win_s),
    .words (data_i),
    .word  (mux_word_s)
  );

  // next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (capture_s) state_nx_s = HOLD;
        else           state_nx_s = IDLE;
      end
      HOLD: begin
        if (capture_s)   state_nx_s = HOLD;
        else if (xfer_s) state_nx_s = IDLE;
        else             state_nx_s = HOLD;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // state and holding register; last resets to 3 so requester 0 leads after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      last_r  <= 2'd3;
      src_r   <= {SEL_W{1'b0}};
      data_r  <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      if (capture_s) begin
        last_r <= win_s;
        src_r  <= win_s;
        data_r <= mux_word_s;
      end
    end
  end

  assign ack_o       = capture_s ? onehot(win_s) : {NUM_REQ{1'b0}};
  assign out_valid_o = (state_r == HOLD);
  assign out_data_o  = data_r;
  assign out_src_o   = src_r;

endmodule
